// File: rtl/lane_scheduler.sv
// lane_scheduler: per-tick combat round sequencer for one lane (player unit vs enemy unit)
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   game_tick                        - one-cycle pulse starting a combat round
//   player_pos, enemy_pos            - 9-bit unit positions, sampled on an accepted tick
//   player_alive, enemy_alive        - unit deployed-and-alive flags, sampled on an accepted tick
//   player_power, enemy_power        - 8-bit attack strengths, sampled on an accepted tick
//   player_move_en, enemy_move_en    - one-cycle move strobes
//   player_dmg_en, enemy_dmg_en      - one-cycle damage-apply strobes
//   dmg_to_player, dmg_to_enemy      - damage values, nonzero only alongside the dmg strobes
//   base_hit                         - one-cycle pulse when the enemy reaches the base
//   busy                             - round in progress
//   engaged                          - result of the latest engagement evaluation
//   overrun_cnt                      - saturating count of ticks dropped while busy
module lane_scheduler #(
    parameter logic [8:0] ENGAGE_DIST = 9'd8,
    parameter logic [8:0] BASE_POS    = 9'd511
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic [8:0] player_pos,
    input  logic [8:0] enemy_pos,
    input  logic       player_alive,
    input  logic       enemy_alive,
    input  logic [7:0] player_power,
    input  logic [7:0] enemy_power,
    output logic       player_move_en,
    output logic       enemy_move_en,
    output logic       player_dmg_en,
    output logic       enemy_dmg_en,
    output logic [7:0] dmg_to_player,
    output logic [7:0] dmg_to_enemy,
    output logic       base_hit,
    output logic       busy,
    output logic       engaged,
    output logic [7:0] overrun_cnt
);
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        EVAL   = 5'b00010,
        MOVE   = 5'b00100,
        ATTACK = 5'b01000,
        SETTLE = 5'b10000
    } state_t;

    state_t     state;
    logic [8:0] snap_ppos, snap_epos;
    logic       snap_palive, snap_ealive;
    logic [7:0] snap_ppower, snap_epower;
    logic       engaged_n;

    // Widen to 10 bits so enemy_pos + ENGAGE_DIST cannot wrap past 511.
    assign engaged_n = snap_palive && snap_ealive &&
                       (({1'b0, snap_epos} + {1'b0, ENGAGE_DIST}) >= {1'b0, snap_ppos});

    assign busy = (state != IDLE);

    // Strobes are registered on the EVAL->MOVE/ATTACK transition so they are
    // high exactly while the state register holds MOVE or ATTACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            snap_ppos      <= '0;
            snap_epos      <= '0;
            snap_palive    <= 1'b0;
            snap_ealive    <= 1'b0;
            snap_ppower    <= '0;
            snap_epower    <= '0;
            player_move_en <= 1'b0;
            enemy_move_en  <= 1'b0;
            player_dmg_en  <= 1'b0;
            enemy_dmg_en   <= 1'b0;
            dmg_to_player  <= '0;
            dmg_to_enemy   <= '0;
            base_hit       <= 1'b0;
            engaged        <= 1'b0;
            overrun_cnt    <= '0;
        end else begin
            player_move_en <= 1'b0;
            enemy_move_en  <= 1'b0;
            player_dmg_en  <= 1'b0;
            enemy_dmg_en   <= 1'b0;
            dmg_to_player  <= '0;
            dmg_to_enemy   <= '0;
            base_hit       <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_tick) begin
                        snap_ppos   <= player_pos;
                        snap_epos   <= enemy_pos;
                        snap_palive <= player_alive;
                        snap_ealive <= enemy_alive;
                        snap_ppower <= player_power;
                        snap_epower <= enemy_power;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    engaged <= engaged_n;
                    if (engaged_n) begin
                        player_dmg_en <= 1'b1;
                        enemy_dmg_en  <= 1'b1;
                        dmg_to_enemy  <= snap_ppower;
                        dmg_to_player <= snap_epower;
                        state         <= ATTACK;
                    end else begin
                        player_move_en <= snap_palive;
                        enemy_move_en  <= snap_ealive && (snap_epos != BASE_POS);
                        base_hit       <= snap_ealive && (snap_epos == BASE_POS);
                        state          <= MOVE;
                    end
                end
                MOVE, ATTACK: state <= SETTLE;
                SETTLE:       state <= IDLE;
                default:      state <= IDLE;
            endcase
            if (game_tick && state != IDLE && overrun_cnt != 8'hff)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: randomized and directed checking of lane_scheduler against a round-level model
module tb_lane_scheduler;
    logic       clk = 1'b0, reset = 1'b1, game_tick = 1'b0;
    logic [8:0] player_pos = '0, enemy_pos = '0;
    logic       player_alive = 1'b0, enemy_alive = 1'b0;
    logic [7:0] player_power = '0, enemy_power = '0;
    logic       player_move_en, enemy_move_en, player_dmg_en, enemy_dmg_en, base_hit, busy, engaged;
    logic [7:0] dmg_to_player, dmg_to_enemy, overrun_cnt;

    lane_scheduler dut (
        .clk(clk), .reset(reset), .game_tick(game_tick),
        .player_pos(player_pos), .enemy_pos(enemy_pos),
        .player_alive(player_alive), .enemy_alive(enemy_alive),
        .player_power(player_power), .enemy_power(enemy_power),
        .player_move_en(player_move_en), .enemy_move_en(enemy_move_en),
        .player_dmg_en(player_dmg_en), .enemy_dmg_en(enemy_dmg_en),
        .dmg_to_player(dmg_to_player), .dmg_to_enemy(dmg_to_enemy),
        .base_hit(base_hit), .busy(busy), .engaged(engaged), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    // Model: ph counts cycles since an accepted tick (0 = idle, 1 = evaluating, 2 = strobes, 3 = settling).
    int ph, s_pp, s_ep, s_ppow, s_epow, m_ovr;
    bit s_pa, s_ea, m_eng;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; m_eng = 0; m_ovr = 0;
        s_pp = 0; s_ep = 0; s_ppow = 0; s_epow = 0; s_pa = 0; s_ea = 0;
    endtask

    task automatic model_step();
        if (reset) model_reset();
        else if (ph == 0) begin
            if (game_tick) begin
                s_pp = player_pos; s_ep = enemy_pos; s_pa = player_alive; s_ea = enemy_alive;
                s_ppow = player_power; s_epow = enemy_power; ph = 1;
            end
        end else begin
            if (game_tick && m_ovr < 255) m_ovr++;
            if (ph == 1) m_eng = s_pa && s_ea && (s_ep + 8 >= s_pp);
            ph = (ph == 3) ? 0 : ph + 1;
        end
    endtask

    task automatic compare();
        bit fight, walk;
        fight = (ph == 2) && m_eng;
        walk  = (ph == 2) && !m_eng;
        chk("busy", busy, ph != 0);
        chk("engaged", engaged, m_eng);
        chk("player_move_en", player_move_en, walk && s_pa);
        chk("enemy_move_en", enemy_move_en, walk && s_ea && s_ep != 511);
        chk("base_hit", base_hit, walk && s_ea && s_ep == 511);
        chk("player_dmg_en", player_dmg_en, fight);
        chk("enemy_dmg_en", enemy_dmg_en, fight);
        chk("dmg_to_enemy", dmg_to_enemy, fight ? s_ppow : 0);
        chk("dmg_to_player", dmg_to_player, fight ? s_epow : 0);
        chk("overrun_cnt", overrun_cnt, m_ovr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_in(int pp, int ep, bit pa, bit ea, int ppow, int epow);
        player_pos = 9'(pp); enemy_pos = 9'(ep); player_alive = pa; enemy_alive = ea;
        player_power = 8'(ppow); enemy_power = 8'(epow);
    endtask

    task automatic all_zero(string tag);
        chk({tag, "_outs"}, {player_move_en, enemy_move_en, player_dmg_en, enemy_dmg_en, base_hit, busy, engaged}, 0);
        chk({tag, "_dmg"}, {dmg_to_player, dmg_to_enemy}, 0);
        chk({tag, "_ovr"}, overrun_cnt, 0);
    endtask

    task automatic start_round();
        game_tick = 1'b1;
        cycle();
        game_tick = 1'b0;
        cycle();
    endtask

    task automatic finish_round();
        cycle(); cycle();
        chk("round_idle", busy, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        all_zero("in_reset");
        compare();
        reset = 1'b0;

        // Move round: both walk, no engagement.
        set_in(200, 100, 1, 1, 5, 6);
        start_round();
        chk("mv_pmove", player_move_en, 1);
        chk("mv_emove", enemy_move_en, 1);
        chk("mv_eng", engaged, 0);
        finish_round();

        // Engage boundary: separation exactly 8 fights, 9 walks.
        set_in(108, 100, 1, 1, 8'h33, 8'h44);
        start_round();
        chk("eng_flag", engaged, 1);
        chk("eng_dmg_enemy", dmg_to_enemy, 8'h33);
        chk("eng_dmg_player", dmg_to_player, 8'h44);
        chk("eng_no_move", player_move_en, 0);
        finish_round();
        set_in(109, 100, 1, 1, 8'h33, 8'h44);
        start_round();
        chk("sep9_eng", engaged, 0);
        chk("sep9_pmove", player_move_en, 1);
        chk("sep9_dmg", dmg_en_sum(), 0);
        finish_round();

        // Base strike with a dead player.
        set_in(0, 511, 0, 1, 9, 9);
        start_round();
        chk("base_hit", base_hit, 1);
        chk("base_moves", {player_move_en, enemy_move_en}, 0);
        chk("base_dmg", {dmg_to_player, dmg_to_enemy}, 0);
        finish_round();

        // Inputs dropping mid-round do not alter the round.
        set_in(300, 100, 1, 1, 1, 2);
        game_tick = 1'b1;
        cycle();
        game_tick = 1'b0;
        set_in(101, 100, 0, 0, 0, 0);
        cycle();
        chk("drop_pmove", player_move_en, 1);
        chk("drop_emove", enemy_move_en, 1);
        finish_round();

        // Overrun: tick at T and T+2.
        set_in(200, 100, 1, 1, 0, 0);
        game_tick = 1'b1; cycle();
        game_tick = 1'b0; cycle();
        game_tick = 1'b1; cycle();
        game_tick = 1'b0; cycle(); cycle();
        chk("ovr_one", overrun_cnt, 1);
        game_tick = 1'b1;
        repeat (420) cycle();
        game_tick = 1'b0;
        repeat (4) cycle();
        chk("ovr_sat", overrun_cnt, 255);

        // Reset asserted in ATTACK clears everything at once, then next tick is accepted.
        set_in(104, 100, 1, 1, 8'h7f, 8'h11);
        start_round();
        chk("pre_rst_dmg", player_dmg_en, 1);
        #2 reset = 1'b1;
        #1 all_zero("async_rst");
        model_reset();
        cycle();
        reset = 1'b0;
        set_in(250, 10, 1, 1, 3, 4);
        start_round();
        chk("post_rst_pmove", player_move_en, 1);
        finish_round();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
                cycle();
                reset = 1'b0;
            end else begin
                int ep, pp;
                ep = ($urandom_range(0, 7) == 0) ? 511 : $urandom_range(0, 511);
                pp = $urandom_range(0, 1) ? ep + $urandom_range(0, 16) : $urandom_range(0, 511);
                if (pp > 511) pp = 511;
                set_in(pp, ep, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 255), $urandom_range(0, 255));
                game_tick = ($urandom_range(0, 2) == 0);
                cycle();
            end
        end
        game_tick = 1'b0;
        repeat (5) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic int dmg_en_sum();
        return int'(player_dmg_en) + int'(enemy_dmg_en);
    endfunction
endmodule

// File: doc/lane_scheduler.md
LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 The module SHALL have parameter ENGAGE_DIST, default 9'd8, giving the separation at or below which the two units fight instead of moving.
REQ-002 The module SHALL have parameter BASE_POS, default 9'd511, giving the enemy position at which the enemy strikes the player base.
REQ-003 Port clk, input, 1 bit: system clock; every register SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port game_tick, input, 1 bit: single-cycle pulse that starts one combat round.
REQ-006 Ports player_pos and enemy_pos, inputs, 9 bits each: current unit positions.
REQ-007 Ports player_alive and enemy_alive, inputs, 1 bit each: high when the unit is deployed and not dead.
REQ-008 Ports player_power and enemy_power, inputs, 8 bits each: attack strength of each unit.
REQ-009 Ports player_move_en and enemy_move_en, outputs, 1 bit each: one-cycle move strobes to the units.
REQ-010 Ports player_dmg_en and enemy_dmg_en, outputs, 1 bit each: one-cycle damage-apply strobes.
REQ-011 Ports dmg_to_player and dmg_to_enemy, outputs, 8 bits each: damage each unit applies on its dmg_en strobe.
REQ-012 Port base_hit, output, 1 bit: one-cycle pulse when the enemy strikes the base.
REQ-013 Ports busy and engaged, outputs, 1 bit each; port overrun_cnt, output, 8 bits.

Function
REQ-014 The FSM SHALL have the states IDLE, EVAL, MOVE, ATTACK and SETTLE, one-hot encoded.
REQ-015 In IDLE, a game_tick SHALL latch both positions, both alive bits and both powers into internal snapshot registers and go to EVAL.
REQ-016 EVAL SHALL compute engaged_n = both snapshot alive bits high AND {1'b0,enemy_pos}+ENGAGE_DIST >= {1'b0,player_pos}, using a 10-bit unsigned compare so the sum cannot wrap.
REQ-017 EVAL SHALL register engaged_n into the engaged output and go to ATTACK if engaged_n=1, else to MOVE.
REQ-018 MOVE SHALL pulse player_move_en for one cycle if the player snapshot is alive.
REQ-019 MOVE SHALL pulse enemy_move_en for one cycle if the enemy snapshot is alive and enemy_pos != BASE_POS.
REQ-020 MOVE SHALL pulse base_hit instead of enemy_move_en when the enemy snapshot is alive and enemy_pos == BASE_POS.
REQ-021 ATTACK SHALL pulse both dmg_en strobes for one cycle, with dmg_to_enemy = player_power snapshot and dmg_to_player = enemy_power snapshot.
REQ-022 Both dmg_to_* outputs SHALL be 8'd0 in every state other than ATTACK.
REQ-023 MOVE and ATTACK SHALL each last exactly one cycle and go to SETTLE; SETTLE SHALL last one cycle and go to IDLE.
REQ-024 Latency: for a tick sampled at edge T, the strobes SHALL be high during cycle T+2 and the FSM SHALL be back in IDLE at T+4.
REQ-025 All strobes SHALL be Moore outputs decoded from the registered state and snapshots.
REQ-026 No strobe SHALL be high outside its state, and MOVE and ATTACK strobes SHALL never be high in the same cycle.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 A game_tick while busy=1 SHALL be ignored and SHALL increment overrun_cnt, saturating at 8'd255.
REQ-029 Input changes after the snapshot SHALL NOT affect the round in progress, including alive bits dropping mid-round.
REQ-030 If both snapshot alive bits are low, the round SHALL still sequence through MOVE, with no strobes asserted.

Reset
REQ-031 While reset is high, the state SHALL be IDLE and all strobes, dmg_to_*, busy, engaged, overrun_cnt and snapshots SHALL be 0.
REQ-032 A reset asserted mid-round SHALL abort the round with no further strobes.
REQ-033 After reset deasserts, the first tick SHALL be accepted.

Verification
REQ-034 Move round: player 200, enemy 100, both alive, tick -> EVAL, then both move_en high for one cycle at T+2, engaged=0, back in IDLE at T+4.
REQ-035 Engage boundary: player 108, enemy 100 gives engaged=1 and dmg_to_enemy=player_power, dmg_to_player=enemy_power for one cycle; player 109 gives MOVE instead.
REQ-036 Base strike: enemy 511 alive, player dead -> base_hit pulses once, no move_en strobes, dmg_to_* = 0.
REQ-037 Overrun: tick at T and again at T+2 -> the second tick is ignored and overrun_cnt=1; 300 overrun ticks leave overrun_cnt=255.
REQ-038 Mid-round events: alive dropping in cycle T+1 has no effect on the round, and reset asserted in ATTACK forces IDLE with all outputs 0 immediately.
